// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//
// AXI4 slave responder backed by an internal single-port synchronous SRAM.
// It serves one INCR burst at a time, either read or write, and accepts one
// beat per cycle when the master does not stall. It terminates the GPGPU's
// AXI master port: L2 fills and writebacks land here.
//
// Ports
//   clk                      system clock
//   reset                    asynchronous, active-low reset
//   awaddr/awlen/awvalid     write address channel in  (awready out)
//   wdata/wlast/wvalid       write data channel in     (wready out)
//                            wlast is ignored; the burst length comes from awlen
//   bready                   write response ready in   (bvalid/bresp out)
//   araddr/arlen/arvalid     read address channel in   (arready out)
//   rready                   read data ready in        (rvalid/rdata/rlast/rresp out)
//
// Addressing: word index = addr[ADDR_BITS+1:2]. The index wraps modulo
// MEM_WORDS inside a burst. SRAM contents are never cleared by reset.
//
// State table
//   ST_IDLE        | arbitrate AW/AR; awready/arready only driven here
//   ST_WRITE_BURST | wready=1, one SRAM write per wvalid beat
//   ST_WRITE_RESP  | bvalid=1 until bready
//   ST_READ_BURST  | SRAM reads issued into the rdata output register
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter  int MEM_WORDS = 4096,
    localparam int ADDR_BITS = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,

    input  logic [31:0] wdata,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,

    output logic        bvalid,
    output logic [1:0]  bresp,
    input  logic        bready,

    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,

    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    input  logic        rready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE_BURST,
        ST_WRITE_RESP,
        ST_READ_BURST
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [8:0]             cnt_q, cnt_d;       // beats still to write / still to issue
    logic                   prio_read_q, prio_read_d;
    logic                   rvalid_q, rvalid_d;
    logic                   rlast_q, rlast_d;
    logic [31:0]            rdata_q;

    logic                   mem_we;
    logic                   mem_re;

    logic [31:0]            mem [MEM_WORDS];

    // Address bits outside the word index and wlast carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{wlast,
                             awaddr[31:ADDR_BITS+2], awaddr[1:0],
                             araddr[31:ADDR_BITS+2], araddr[1:0]};

    // Handshake readies are combinational and gated by reset so that every
    // ready/valid output drops the instant reset is asserted, even while the
    // master keeps its valids high.
    always_comb begin
        awready = reset && (state_q == ST_IDLE) && awvalid
                  && (!arvalid || !prio_read_q);
        arready = reset && (state_q == ST_IDLE) && arvalid && !awready;
    end

    assign wready = (state_q == ST_WRITE_BURST);
    assign bvalid = (state_q == ST_WRITE_RESP);
    assign bresp  = 2'b00;
    assign rresp  = 2'b00;
    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign rdata  = rdata_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        prio_read_d = prio_read_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (awready) begin
                    idx_d       = awaddr[ADDR_BITS+1:2];
                    cnt_d       = {1'b0, awlen} + 9'd1;
                    state_d     = ST_WRITE_BURST;
                    prio_read_d = 1'b1;
                end else if (arready) begin
                    idx_d       = araddr[ADDR_BITS+1:2];
                    cnt_d       = {1'b0, arlen} + 9'd1;
                    state_d     = ST_READ_BURST;
                    prio_read_d = 1'b0;
                end
            end

            ST_WRITE_BURST: begin
                if (wvalid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = ST_WRITE_RESP;
                    end
                end
            end

            ST_WRITE_RESP: begin
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_READ_BURST: begin
                // Issue a new read only when the output register is empty or
                // being drained this cycle; otherwise the held beat stays put.
                mem_re = (cnt_q != 9'd0) && (!rvalid_q || rready);
                if (mem_re) begin
                    idx_d    = idx_q + 1'b1;
                    cnt_d    = cnt_q - 9'd1;
                    rvalid_d = 1'b1;
                    rlast_d  = (cnt_q == 9'd1);
                end else if (rready) begin
                    rvalid_d = 1'b0;
                end
                if (rvalid_q && rready && rlast_q) begin
                    state_d = ST_IDLE;
                    rlast_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            prio_read_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            prio_read_q <= prio_read_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
        end
    end

    // SRAM array plus its output register; deliberately not reset so memory
    // survives a reset and the block maps onto plain block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata;
        end
        if (mem_re) begin
            rdata_q <= mem[idx_q];
        end
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 slave-side responder with an internal single-port synchronous SRAM; the far end of the GPGPU's AXI master port.
- Used as the on-chip system memory in simulation and FPGA builds: the L2 cache fills and writebacks terminate here.
- Serves one INCR burst at a time, read or write, with full rready backpressure.
- Sustains one beat per cycle when the master does not stall.

Parameters:
- MEM_WORDS, 4096, depth in 32-bit words; power of two.
- ADDR_BITS, $clog2(MEM_WORDS), word index width (derived; not overridden).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low; "one clock; reset is asynchronous and active-low".
- axi_bus  axi_interface.slave  —  signals used:
  - awaddr/araddr 32
  - awlen/arlen 8
  - awvalid/arvalid/wvalid/bready/rready 1 (input)
  - wdata 32 (input)
  - wlast 1 (input, ignored)
  - awready/arready/wready/bvalid/rvalid/rlast 1 (output)
  - rdata 32 (output)
  - bresp/rresp tied OKAY.

Behaviour:
- States: IDLE, WRITE_BURST, WRITE_RESP, READ_BURST.
- Reset asserted (any cycle, including mid-burst):
  - state=IDLE; awready/arready/wready/bvalid/rvalid/rlast=0.
  - Beat counters cleared; priority bit=write-first.
  - SRAM contents are NOT cleared.
  - An in-flight burst is abandoned silently.
- Address mapping: word index = addr[ADDR_BITS+1:2]; addr[1:0] ignored. Index increments per beat and wraps modulo MEM_WORDS (no error).
- Beat count = len+1 (1..256).
- IDLE:
  - awready = awvalid && (!arvalid || !prio_read).
  - arready = arvalid && !awready.
  - Both driven combinationally, only in IDLE.
  - On AW handshake: latch index and count, go to WRITE_BURST, prio_read<=1.
  - On AR handshake: latch index and count, go to READ_BURST, prio_read<=0.
  - A simultaneous AW and AR with prio_read=0 accepts the write; the read stays pending and is accepted next IDLE cycle.
- WRITE_BURST:
  - wready=1.
  - Each wvalid cycle writes wdata to mem[index] at the clock edge, then index++ and count--.
  - Burst ends on count, not wlast. The final beat moves to WRITE_RESP.
- WRITE_RESP:
  - bvalid=1, held until bready; then go to IDLE.
  - Earliest next AW accept is the cycle after the B handshake.
- READ_BURST:
  - SRAM read enable re = (remaining>0) && (!rvalid || rready).
  - SRAM output register drives rdata directly and holds when re=0.
  - rvalid <= re ? 1 : (rready ? 0 : rvalid).
  - rlast is registered alongside rdata and is 1 on the beat issued with remaining==1.
  - First rvalid appears 2 cycles after the AR handshake cycle.
  - With rready=1, rvalid stays high for count consecutive cycles.
  - rdata/rlast are stable while rvalid && !rready.
  - Go to IDLE in the cycle the rlast beat handshakes.
- Read-after-write: a read issued after bvalid sees the written data; there is no bypass path.
- Single port: reads and writes never overlap, by construction of the FSM.

Test Plan:
- Reset, then write burst awaddr=0x100, awlen=3, wdata 0xA0..0xA3, wvalid continuous:
  - awready in the AW cycle, 4 wready beats, then bvalid one cycle later.
  - Read araddr=0x100, arlen=3 returns 0xA0..0xA3 on 4 consecutive cycles, rlast on 0xA3, first rvalid 2 cycles after the AR handshake.
- Read the same burst with rready toggling 1,0,0,1,0,1…:
  - Each beat holds stable while stalled.
  - Order is 0xA0..0xA3 with no duplicates or drops.
  - rlast appears only with 0xA3.
- Simultaneous awvalid and arvalid in IDLE after reset:
  - Write accepted first.
  - Read accepted the cycle after the B handshake.
  - With both valid again, the read now wins.
- Wrap: MEM_WORDS=4096, write awaddr=0x3FFC, awlen=1, data 0x11, 0x22:
  - Reading word 4095 gives 0x11; reading word 0 gives 0x22.
- wlast mismatch: awlen=1 with wlast asserted on beat 0:
  - Two beats are still accepted.
  - bvalid only after the second beat.
- Reset asserted mid read burst (beat 2 of 8):
  - All valid/ready outputs are 0 immediately, asynchronously.
  - After release, a fresh read returns previously written data (memory retained).
